spi_mem_ctrl: RTL and testbench

//  Parametrised SPI master for serial SRAM/flash (23LC-style READ 0x03 / WRITE 0x02 opcodes).

---
 rtl/spi_mem_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_spi_mem_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_ctrl.sv
// SPI mode-0 master for serial SRAM/flash: opcode, MSB-first address, then a burst of data bytes.
// Latency: first sclk rise CLK_DIV clk after start; busy for (8+ADDR_W+8*bytes)*2*CLK_DIV+CLK_DIV+1 clk.
// Backpressure: none; write bytes must be valid in the wdata_ack cycle, rd_valid cannot stall, start ignored while busy.
module spi_mem_ctrl #(
    parameter int         ADDR_W    = 16,
    parameter int         CLK_DIV   = 2,
    parameter int         BURST_W   = 3,
    parameter logic [7:0] CMD_READ  = 8'h03,
    parameter logic [7:0] CMD_WRITE = 8'h02
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               write,
    input  logic [ADDR_W-1:0]  address,
    input  logic [BURST_W-1:0] burst_len,
    input  logic [7:0]         wdata,
    output logic               wdata_ack,
    output logic [7:0]         rdata,
    output logic               rd_valid,
    output logic               busy,
    output logic               done,
    output logic               sclk,
    output logic               cs_n,
    output logic               mosi,
    input  logic               miso
);

    // cnt has to reach CLK_DIV during the deselect gap, one more than a half period needs
    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(ADDR_W);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_PRE  = CNT_W'(CLK_DIV - 2);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CLK_DIV);
    localparam logic [BIT_W-1:0] BYTE_TOP  = BIT_W'(7);
    localparam logic [BIT_W-1:0] ADDR_TOP  = BIT_W'(ADDR_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_GAP
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;          // clk cycles within the current sclk half period / gap
    logic [BIT_W-1:0]   bit_idx;      // bits left in the current segment after this one
    logic [BURST_W-1:0] byte_cnt;     // data bytes left after the current one
    logic [ADDR_W-1:0]  addr_lat;
    logic [ADDR_W-1:0]  tx_sr;        // outgoing bits, next bit to send sits at the top
    logic [7:0]         rx_sr;
    logic               wr_mode;
    logic               rx_byte_done; // 8th data bit captured on the previous edge

    logic [7:0] opcode;
    logic       half_end;
    logic       seg_last;
    logic       next_is_data_byte;
    logic       last_cycle_next;

    assign opcode   = write ? CMD_WRITE : CMD_READ;
    assign half_end = (cnt == HALF_LAST);
    assign seg_last = (bit_idx == '0);

    // The bit now on the wire is the last before a fresh data byte starts
    assign next_is_data_byte = seg_last &&
                               ((state == S_ADDR) || ((state == S_DATA) && (byte_cnt != '0)));

    // The coming cycle is the final cycle of the current bit (sclk high, about to fall).
    // wdata_ack is raised for that cycle so the byte is latched on the edge that starts it.
    assign last_cycle_next = (CLK_DIV == 1) ? !sclk : (sclk && (cnt == HALF_PRE));

    // Transaction sequencer: owns every output and all shift state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            byte_cnt     <= '0;
            addr_lat     <= '0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            wr_mode      <= 1'b0;
            rx_byte_done <= 1'b0;
            wdata_ack    <= 1'b0;
            rdata        <= '0;
            rd_valid     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sclk         <= 1'b0;
            cs_n         <= 1'b1;
            mosi         <= 1'b0;
        end else begin
            wdata_ack    <= 1'b0;
            rx_byte_done <= 1'b0;
            // a received byte is published one clk after its last sclk rise
            rd_valid     <= rx_byte_done;
            if (rx_byte_done) begin
                rdata <= rx_sr;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        wr_mode  <= write;
                        addr_lat <= address;
                        byte_cnt <= burst_len;
                        tx_sr    <= ADDR_W'(opcode) << (ADDR_W - 8);
                        mosi     <= opcode[7];
                        cs_n     <= 1'b0;
                        sclk     <= 1'b0;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        bit_idx  <= BYTE_TOP;
                        state    <= S_CMD;
                    end
                end

                S_CMD, S_ADDR, S_DATA: begin
                    if (wr_mode && last_cycle_next && next_is_data_byte) begin
                        wdata_ack <= 1'b1;
                    end
                    if (!half_end) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt  <= '0;
                        sclk <= !sclk;
                        if (!sclk) begin
                            // rising sclk: the memory's bit is stable, capture it
                            if ((state == S_DATA) && !wr_mode) begin
                                rx_sr <= {rx_sr[6:0], miso};
                                if (seg_last) begin
                                    rx_byte_done <= 1'b1;
                                end
                            end
                        end else if (!seg_last) begin
                            // falling sclk inside a segment: present the next bit
                            bit_idx <= bit_idx - 1'b1;
                            tx_sr   <= tx_sr << 1;
                            mosi    <= tx_sr[ADDR_W-2];
                        end else if (state == S_CMD) begin
                            state   <= S_ADDR;
                            bit_idx <= ADDR_TOP;
                            tx_sr   <= addr_lat;
                            mosi    <= addr_lat[ADDR_W-1];
                        end else if ((state == S_ADDR) || (byte_cnt != '0)) begin
                            // next data byte; the memory auto-increments its address
                            if (state == S_DATA) begin
                                byte_cnt <= byte_cnt - 1'b1;
                            end
                            state   <= S_DATA;
                            bit_idx <= BYTE_TOP;
                            tx_sr   <= wr_mode ? (ADDR_W'(wdata) << (ADDR_W - 8)) : '0;
                            mosi    <= wr_mode & wdata[7];
                        end else begin
                            state <= S_GAP;
                            cs_n  <= 1'b1;
                            mosi  <= 1'b0;
                        end
                    end
                end

                S_GAP: begin
                    // deselect window: CLK_DIV cycles, then the done cycle
                    cnt <= cnt + 1'b1;
                    if (cnt == HALF_LAST) begin
                        done <= 1'b1;
                    end
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl: default instance (ADDR_W=16, CLK_DIV=2) and a fast 24-bit instance.
// Latency: n/a (bench).
// Backpressure: n/a (bench); a small SPI slave model answers miso and records mosi bytes.
module tb_spi_mem_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // default instance
    logic        start = 1'b0;
    logic        write = 1'b0;
    logic [15:0] address = '0;
    logic [2:0]  burst_len = '0;
    logic [7:0]  wdata = '0;
    logic        wdata_ack, rd_valid, busy, done, sclk, cs_n, mosi, miso;
    logic [7:0]  rdata;

    // ADDR_W=24, CLK_DIV=1 instance
    logic        start2 = 1'b0;
    logic [23:0] address2 = '0;
    logic [2:0]  burst_len2 = '0;
    logic [7:0]  wdata2 = '0;
    logic        wdata_ack2, rd_valid2, busy2, done2, sclk2, cs_n2, mosi2, miso2;
    logic [7:0]  rdata2;

    spi_mem_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .write(write), .address(address),
        .burst_len(burst_len), .wdata(wdata), .wdata_ack(wdata_ack), .rdata(rdata),
        .rd_valid(rd_valid), .busy(busy), .done(done), .sclk(sclk), .cs_n(cs_n),
        .mosi(mosi), .miso(miso)
    );

    spi_mem_ctrl #(.ADDR_W(24), .CLK_DIV(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .write(1'b0), .address(address2),
        .burst_len(burst_len2), .wdata(wdata2), .wdata_ack(wdata_ack2), .rdata(rdata2),
        .rd_valid(rd_valid2), .busy(busy2), .done(done2), .sclk(sclk2), .cs_n(cs_n2),
        .mosi(mosi2), .miso(miso2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- slave model, default instance ----------------
    logic [63:0] rd_stream = '0;   // bytes the memory returns, first byte in the top bits
    logic [63:0] wr_stream = '0;   // bytes upstream offers on successive acks
    logic [7:0]  mosi_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  sh = '0;
    int          rise_cnt = 0, ack_cnt = 0, wr_idx = 0, done_cnt = 0, cs_win = 0;
    logic        ack_pend = 1'b0, prev_sclk = 1'b0, prev_cs_n = 1'b1;

    always @(negedge clk) begin
        if (prev_cs_n && !cs_n) begin
            rise_cnt = 0;
            mosi_q.delete();
            rd_q.delete();
            ack_cnt  = 0;
            wr_idx   = 0;
            ack_pend = 1'b0;
            wdata    = wr_stream[63:56];
            cs_win++;
        end
        // advance the offered byte only after the ack cycle has closed
        if (ack_pend) begin
            wr_idx++;
            wdata = wr_stream[8*(7-(wr_idx%8)) +: 8];
        end
        ack_pend = wdata_ack;
        if (wdata_ack) ack_cnt++;
        if (rd_valid)  rd_q.push_back(rdata);
        if (done)      done_cnt++;
        if (!prev_sclk && sclk && !cs_n) begin
            sh = {sh[6:0], mosi};
            rise_cnt++;
            if (rise_cnt % 8 == 0) mosi_q.push_back(sh);
        end
        prev_sclk = sclk;
        prev_cs_n = cs_n;
    end

    always_comb begin
        miso = 1'b0;
        if (rise_cnt >= 24) miso = rd_stream[6'(63 - ((rise_cnt - 24) % 64))];
    end

    // ---------------- slave model, 24-bit instance ----------------
    logic [63:0] rd_stream2 = '0;
    logic [7:0]  mosi2_q[$];
    logic [7:0]  rd2_q[$];
    logic [7:0]  sh2 = '0;
    int          rise2 = 0, cyc2 = 0, last_rise2 = -1, per_min2 = 999, per_max2 = 0;
    int          done2_cnt = 0, ack2_cnt = 0;
    logic        prev_sclk2 = 1'b0, prev_cs2 = 1'b1;

    always @(negedge clk) begin
        cyc2++;
        if (prev_cs2 && !cs_n2) begin
            rise2 = 0;
            mosi2_q.delete();
            rd2_q.delete();
            last_rise2 = -1;
            per_min2   = 999;
            per_max2   = 0;
        end
        if (rd_valid2)  rd2_q.push_back(rdata2);
        if (done2)      done2_cnt++;
        if (wdata_ack2) ack2_cnt++;
        if (!prev_sclk2 && sclk2 && !cs_n2) begin
            sh2 = {sh2[6:0], mosi2};
            rise2++;
            if (rise2 % 8 == 0) mosi2_q.push_back(sh2);
            if (last_rise2 >= 0) begin
                if (cyc2 - last_rise2 < per_min2) per_min2 = cyc2 - last_rise2;
                if (cyc2 - last_rise2 > per_max2) per_max2 = cyc2 - last_rise2;
            end
            last_rise2 = cyc2;
        end
        prev_sclk2 = sclk2;
        prev_cs2   = cs_n2;
    end

    always_comb begin
        miso2 = 1'b0;
        if (rise2 >= 32) miso2 = rd_stream2[6'(63 - ((rise2 - 32) % 64))];
    end

    // ---------------- helpers ----------------
    task automatic run_txn(input logic wr, input logic [15:0] a, input logic [2:0] len,
                           output int bcyc);
        @(posedge clk); #1;
        write = wr; address = a; burst_len = len; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bcyc  = 0;
        while (busy && bcyc < 2000) begin
            @(posedge clk); #1;
            bcyc++;
        end
        write = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_mosi(input string tag, input logic [95:0] exp, input int n);
        chk({tag, " nbytes"}, mosi_q.size(), n);
        for (int i = 0; i < n; i++)
            chk($sformatf("%s byte%0d", tag, i),
                (i < mosi_q.size()) ? 32'(mosi_q[i]) : 32'hDEAD,
                32'(exp[8*(n-1-i) +: 8]));
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int bcyc, n, d0, w0;

        // reset state, during and after reset
        repeat (2) @(posedge clk);
        #2;
        chk("rst outs", {cs_n, sclk, mosi, busy, done, rd_valid, wdata_ack}, 7'b1000000);
        chk("rst rdata", rdata, 8'h00);
        chk("rst outs2", {cs_n2, sclk2, busy2}, 3'b100);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle outs", {cs_n, sclk, mosi, busy, done}, 5'b10000);

        // single-byte read @0x1234
        rd_stream = {8'hA5, 56'h0};
        d0 = done_cnt;
        run_txn(1'b0, 16'h1234, 3'd0, bcyc);
        chk("rd1 busy cycles", bcyc, 131);
        chk_mosi("rd1 mosi", 96'h03123400, 4);
        chk("rd1 sclk rises", rise_cnt, 32);
        chk("rd1 rd_valid count", rd_q.size(), 1);
        chk("rd1 rdata", rdata, 8'hA5);
        chk("rd1 done count", done_cnt - d0, 1);
        chk("rd1 acks", ack_cnt, 0);

        // 4-byte write burst @0x00FF
        wr_stream = 64'h11223344_00000000;
        run_txn(1'b1, 16'h00FF, 3'd3, bcyc);
        chk("wr4 busy cycles", bcyc, 227);
        chk_mosi("wr4 mosi", 96'h0200FF11223344, 7);
        chk("wr4 acks", ack_cnt, 4);
        chk("wr4 sclk rises", rise_cnt, 56);
        chk("wr4 rd_valid count", rd_q.size(), 0);
        chk("wr4 rdata held", rdata, 8'hA5);

        // maximum read burst
        rd_stream = 64'h00010203_04050607;
        run_txn(1'b0, 16'h0100, 3'd7, bcyc);
        chk("rd8 busy cycles", bcyc, 355);
        chk_mosi("rd8 mosi", 96'h030100_0000000000000000, 11);
        chk("rd8 rd_valid count", rd_q.size(), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("rd8 rdata%0d", i), (i < rd_q.size()) ? 32'(rd_q[i]) : 32'hDEAD, i);
        chk("rd8 acks", ack_cnt, 0);

        // start while busy and in the done cycle must be ignored
        rd_stream = {8'h5C, 56'h0};
        d0 = done_cnt;
        w0 = cs_win;
        @(posedge clk); #1;
        write = 1'b0; address = 16'h5A5A; burst_len = 3'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        start = 1'b1; write = 1'b1; address = 16'hFFFF; burst_len = 3'd7;
        @(posedge clk); #1;
        start = 1'b0; write = 1'b0;
        n = 0;
        while (!done && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ign done seen", done, 1'b1);
        start = 1'b1; write = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; write = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("ign busy after", busy, 1'b0);
        chk("ign cs windows", cs_win - w0, 1);
        chk("ign done count", done_cnt - d0, 1);
        chk_mosi("ign mosi", 96'h035A5A00, 4);
        chk("ign acks", ack_cnt, 0);
        chk("ign rdata", rdata, 8'h5C);

        // asynchronous reset in the middle of the address phase
        @(posedge clk); #1;
        address = 16'h1234; burst_len = 3'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (rise_cnt != 13 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("arst reached addr bit5", rise_cnt, 13);
        chk("arst busy before", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst outs", {cs_n, sclk, busy, mosi, done}, 5'b10000);
        @(posedge clk); #1;
        rst = 1'b0;
        rd_stream = {8'hA5, 56'h0};
        run_txn(1'b0, 16'h1234, 3'd0, bcyc);
        chk("post-rst busy cycles", bcyc, 131);
        chk_mosi("post-rst mosi", 96'h03123400, 4);
        chk("post-rst rdata", rdata, 8'hA5);

        // 24-bit address, CLK_DIV=1 read @0xABCDEF
        rd_stream2 = {8'h3C, 56'h0};
        @(posedge clk); #1;
        address2 = 24'hABCDEF; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        bcyc = 0;
        while (busy2 && bcyc < 2000) begin
            @(posedge clk); #1;
            bcyc++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("a24 busy cycles", bcyc, 82);
        chk("a24 sclk rises", rise2, 40);
        chk("a24 nbytes", mosi2_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            logic [39:0] exp24;
            exp24 = 40'h03ABCDEF00;
            chk($sformatf("a24 byte%0d", i), (i < mosi2_q.size()) ? 32'(mosi2_q[i]) : 32'hDEAD,
                32'(exp24[8*(4-i) +: 8]));
        end
        chk("a24 sclk period min", per_min2, 2);
        chk("a24 sclk period max", per_max2, 2);
        chk("a24 rdata", rdata2, 8'h3C);
        chk("a24 rd_valid count", rd2_q.size(), 1);
        chk("a24 done count", done2_cnt, 1);
        chk("a24 acks", ack2_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
